// File: rtl/interrupt_ctrl_pkg.sv
// Shared CPU package for the interrupt controller.
// Holds IRQ source indices, the IE/IF register addresses and the
// dispatch state encoding used by interrupt_ctrl.
package interrupt_ctrl_pkg;

   localparam int NUM_IRQ = 5;

   localparam logic [2:0] IRQ_VBLANK = 3'd0;
   localparam logic [2:0] IRQ_STAT   = 3'd1;
   localparam logic [2:0] IRQ_TIMER  = 3'd2;
   localparam logic [2:0] IRQ_SERIAL = 3'd3;
   localparam logic [2:0] IRQ_JOYPAD = 3'd4;

   localparam logic [15:0] ADDR_IF = 16'hFF0F;
   localparam logic [15:0] ADDR_IE = 16'hFFFF;

   typedef enum logic [1:0] {
      INT_IDLE    = 2'd0,
      INT_REQ     = 2'd1,
      INT_SERVICE = 2'd2
   } int_state_e;

endpackage

// File: rtl/interrupt_ctrl_prio_enc.sv
// int_prio_enc: combinational 5->3 priority encoder.
// The lowest set bit wins (VBlank highest priority).
// Ports:
//   req   in  5  pending sources
//   idx   out 3  index of the lowest set bit (0 when none)
//   valid out 1  any bit set
module int_prio_enc
   import interrupt_ctrl_pkg::*;
(
   input  logic [NUM_IRQ-1:0] req,
   output logic [2:0]         idx,
   output logic               valid
);

   // Scan high to low so the lowest set index is the last assignment.
   always_comb begin
      idx = 3'd0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (req[i]) idx = 3'(i);
      end
   end

   assign valid = |req;

endmodule

// File: rtl/interrupt_ctrl.sv
// interrupt_ctrl: IE/IF registers, IME flag and dispatch handshake for
// the PC stage. The PC stage forms the vector 0x0040 + 8*int_active_prio.
// Ports:
//   clock, reset (sync, active low)
//   irq_in[4:0]        peripheral set pulses
//   addr, data_bus,
//   mem_write          CPU bus write to IE (0xFFFF) / IF (0xFF0F)
//   ei_exec, di_exec,
//   reti_exec,
//   instr_done         decode strobes
//   int_ack,
//   dispatch_done      control unit handshake
//   int_request        interrupt ready for dispatch
//   int_active_prio    latched priority index
//   wake               halt/stop exit (any pending, ignores IME)
//   ime                master enable
//   reg_out, reg_hit   combinational IE/IF read port
// Build option: INT_CTRL_EI_DELAY_EN delays EI until the instruction
// after EI has completed.
module interrupt_ctrl
   import interrupt_ctrl_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic [4:0]  irq_in,
   input  logic [15:0] addr,
   input  logic [7:0]  data_bus,
   input  logic        mem_write,
   input  logic        ei_exec,
   input  logic        di_exec,
   input  logic        reti_exec,
   input  logic        instr_done,
   input  logic        int_ack,
   input  logic        dispatch_done,
   output logic        int_request,
   output logic [2:0]  int_active_prio,
   output logic        wake,
   output logic        ime,
   output logic [7:0]  reg_out,
   output logic        reg_hit
);

   logic [7:0]         ie_r;
   logic [4:0]         if_r;
   logic [4:0]         if_nxt;
   logic [4:0]         pending;
   logic [2:0]         enc_idx;
   logic               enc_valid;
   logic               ack_fire;
   logic               ime_set_ei;
   int_state_e         state, state_nxt;

   assign pending = ie_r[4:0] & if_r;

   int_prio_enc u_enc (
      .req   (pending),
      .idx   (enc_idx),
      .valid (enc_valid)
   );

   // Ack uses the pre-write pending value; registers update afterwards.
   assign ack_fire = (state == INT_REQ) && int_ack && enc_valid;

   // IF: write, then ack clear, then new sets (sets always win).
   always_comb begin
      if_nxt = if_r;
      if (mem_write && addr == ADDR_IF) if_nxt = data_bus[4:0];
      if (ack_fire) if_nxt[enc_idx] = 1'b0;
      if_nxt = if_nxt | irq_in;
   end

`ifdef INT_CTRL_EI_DELAY_EN
   // ei_armed: EI seen; ei_seen: first instr_done (EI itself) consumed.
   logic ei_armed, ei_seen;
   assign ime_set_ei = ei_armed && ei_seen && instr_done && !ei_exec;

   always_ff @(posedge clock) begin
      if (!reset || di_exec) begin
         ei_armed <= 1'b0;
         ei_seen  <= 1'b0;
      end else if (ei_exec) begin
         ei_armed <= 1'b1;
         ei_seen  <= 1'b0;
      end else if (ei_armed && instr_done) begin
         if (ei_seen) ei_armed <= 1'b0;
         ei_seen <= ~ei_seen;
      end
   end
`else
   logic unused_instr_done;
   assign unused_instr_done = instr_done;
   assign ime_set_ei = ei_exec;
`endif

   always_ff @(posedge clock) begin
      if (!reset) begin
         ie_r            <= 8'h00;
         if_r            <= 5'h00;
         ime             <= 1'b0;
         state           <= INT_IDLE;
         int_active_prio <= 3'd0;
      end else begin
         if (mem_write && addr == ADDR_IE) ie_r <= data_bus;
         if_r  <= if_nxt;
         state <= state_nxt;
         if (ack_fire) int_active_prio <= enc_idx;
         // Clears (DI, dispatch) beat sets (RETI, EI).
         if (di_exec || ack_fire)          ime <= 1'b0;
         else if (reti_exec || ime_set_ei) ime <= 1'b1;
      end
   end

   always_comb begin
      state_nxt   = state;
      int_request = 1'b0;
      unique case (state)
         INT_IDLE:
            if (ime && enc_valid) state_nxt = INT_REQ;
         INT_REQ: begin
            int_request = enc_valid;
            if (ack_fire)                  state_nxt = INT_SERVICE;
            else if (!enc_valid || !ime)   state_nxt = INT_IDLE;
         end
         INT_SERVICE:
            if (dispatch_done) state_nxt = INT_IDLE;
         default: state_nxt = INT_IDLE;
      endcase
   end

   assign wake    = enc_valid;
   assign reg_hit = (addr == ADDR_IF) || (addr == ADDR_IE);

   always_comb begin
      reg_out = 8'h00;
      if (addr == ADDR_IF)      reg_out = {3'b111, if_r};
      else if (addr == ADDR_IE) reg_out = ie_r;
   end

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Directed bench for interrupt_ctrl with hand-computed expectations.
module tb_interrupt_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic [4:0]  irq_in;
   logic [15:0] addr;
   logic [7:0]  data_bus;
   logic        mem_write, ei_exec, di_exec, reti_exec, instr_done;
   logic        int_ack, dispatch_done;
   logic        int_request, wake, ime, reg_hit;
   logic [2:0]  int_active_prio;
   logic [7:0]  reg_out;

   int checks = 0;
   int errors = 0;

   interrupt_ctrl dut (
      .clock(clock), .reset(reset), .irq_in(irq_in), .addr(addr),
      .data_bus(data_bus), .mem_write(mem_write), .ei_exec(ei_exec),
      .di_exec(di_exec), .reti_exec(reti_exec), .instr_done(instr_done),
      .int_ack(int_ack), .dispatch_done(dispatch_done),
      .int_request(int_request), .int_active_prio(int_active_prio),
      .wake(wake), .ime(ime), .reg_out(reg_out), .reg_hit(reg_hit)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
      addr = a; data_bus = d; mem_write = 1'b1;
      tick();
      mem_write = 1'b0; addr = 16'h0000; data_bus = 8'h00;
   endtask

   task automatic rd(input string tag, input logic [15:0] a, input logic [7:0] exp);
      addr = a;
      #1;
      chk(tag, {8'h00, reg_out}, {8'h00, exp});
      addr = 16'h0000;
   endtask

   task automatic irq(input logic [4:0] v);
      irq_in = v; tick(); irq_in = 5'h00;
   endtask

   task automatic reti();
      reti_exec = 1'b1; tick(); reti_exec = 1'b0;
   endtask

   task automatic ack();
      int_ack = 1'b1; tick(); int_ack = 1'b0;
   endtask

   task automatic done();
      dispatch_done = 1'b1; tick(); dispatch_done = 1'b0;
   endtask

   initial begin
      reset = 1'b0; irq_in = 5'h00; addr = 16'h0000; data_bus = 8'h00;
      mem_write = 1'b0; ei_exec = 1'b0; di_exec = 1'b0; reti_exec = 1'b0;
      instr_done = 1'b0; int_ack = 1'b0; dispatch_done = 1'b0;
      tick(); tick();

      // reset state
      chk("rst_ime", ime, 0);
      chk("rst_req", int_request, 0);
      chk("rst_prio", int_active_prio, 0);
      chk("rst_wake", wake, 0);
      rd("rst_ie", 16'hFFFF, 8'h00);
      rd("rst_if", 16'hFF0F, 8'hE0);
      addr = 16'hFF0F; #1; chk("hit_if", reg_hit, 1);
      addr = 16'h1234; #1; chk("hit_none", reg_hit, 0);
      addr = 16'h0000;
      reset = 1'b1;

      // basic dispatch: IE=1F, IME=1, irq 10100 -> prio 2
      bus_wr(16'hFFFF, 8'h1F);
      reti();
      chk("b_ime", ime, 1);
      irq(5'b10100);
      chk("b_wake", wake, 1);
      chk("b_req0", int_request, 0);
      rd("b_if", 16'hFF0F, 8'hF4);
      tick();
      chk("b_req1", int_request, 1);
      ack();
      chk("b_prio", int_active_prio, 2);
      rd("b_if_clr", 16'hFF0F, 8'hF0);
      chk("b_ime0", ime, 0);
      chk("b_req_srv", int_request, 0);
      done();
      tick(); tick();
      chk("b_norereq", int_request, 0);
      chk("b_prio_hold", int_active_prio, 2);
      bus_wr(16'hFF0F, 8'h00);

      // wake without IME
      bus_wr(16'hFFFF, 8'h01);
      irq(5'b00001);
      chk("w_wake", wake, 1);
      tick();
      chk("w_noreq", int_request, 0);
      bus_wr(16'hFF0F, 8'h00);
      chk("w_wake0", wake, 0);

      // set beats same-cycle write
      addr = 16'hFF0F; data_bus = 8'h00; mem_write = 1'b1; irq_in = 5'b01000;
      tick();
      mem_write = 1'b0; irq_in = 5'h00; addr = 16'h0000;
      rd("set_wins", 16'hFF0F, 8'hE8);
      bus_wr(16'hFF0F, 8'h00);

      // EI latency
      irq(5'b00001);
      ei_exec = 1'b1; tick(); ei_exec = 1'b0;
`ifdef INT_CTRL_EI_DELAY_EN
      chk("ei_ime_wait", ime, 0);
      instr_done = 1'b1; tick(); instr_done = 1'b0;
      chk("ei_ime_wait2", ime, 0);
      tick();
      chk("ei_noreq", int_request, 0);
      instr_done = 1'b1; tick(); instr_done = 1'b0;
`endif
      chk("ei_ime", ime, 1);
      tick();
      chk("ei_req", int_request, 1);
      ack();
      chk("ei_prio", int_active_prio, 0);
      done();

      // higher priority during SERVICE does not move prio
      bus_wr(16'hFFFF, 8'h1F);
      irq(5'b10000);
      reti();
      tick();
      chk("s_req", int_request, 1);
      ack();
      chk("s_prio4", int_active_prio, 4);
      irq(5'b00001);
      chk("s_prio_hold", int_active_prio, 4);
      chk("s_noreq", int_request, 0);
      done();
      tick();
      chk("s_idle_noreq", int_request, 0);
      reti();
      tick();
      chk("s_req2", int_request, 1);
      ack();
      chk("s_prio0", int_active_prio, 0);
      done();

      // DI beats EI
      reti();
      ei_exec = 1'b1; di_exec = 1'b1; tick(); ei_exec = 1'b0; di_exec = 1'b0;
      chk("di_wins", ime, 0);
      tick(); tick();
      chk("di_wins_late", ime, 0);

      // ack uses pre-write pending when IE written same cycle
      irq(5'b00101);
      reti();
      tick();
      chk("aw_req", int_request, 1);
      addr = 16'hFFFF; data_bus = 8'h04; mem_write = 1'b1; int_ack = 1'b1;
      tick();
      mem_write = 1'b0; int_ack = 1'b0; addr = 16'h0000;
      chk("aw_prio", int_active_prio, 0);
      rd("aw_if", 16'hFF0F, 8'hE4);
      rd("aw_ie", 16'hFFFF, 8'h04);
      done();
      bus_wr(16'hFF0F, 8'h00);

      // reset in REQ
      irq(5'b00100);
      reti();
      tick();
      chk("rr_req", int_request, 1);
      reset = 1'b0; tick(); reset = 1'b1;
      chk("rr_req0", int_request, 0);
      chk("rr_ime", ime, 0);
      rd("rr_ie", 16'hFFFF, 8'h00);
      rd("rr_if", 16'hFF0F, 8'hE0);

      // reset in SERVICE
      bus_wr(16'hFFFF, 8'h1F);
      irq(5'b00010);
      reti();
      tick();
      ack();
      chk("rs_prio", int_active_prio, 1);
      reset = 1'b0; tick(); reset = 1'b1;
      chk("rs_prio0", int_active_prio, 0);
      chk("rs_ime", ime, 0);
      chk("rs_req", int_request, 0);
      rd("rs_ie", 16'hFFFF, 8'h00);
      rd("rs_if", 16'hFF0F, 8'hE0);
      done();
      chk("rs_after", int_request, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
